// File: rtl/wbuf_bank.sv
// Double-buffered weight bank: 64 x DW entries per bank with per-bank valid bitmaps.
// Writes land one cycle after the request, which lines them up with the SRAM read latency.
module wbuf_bank #(
   parameter int DW = 16
) (
   input  logic             CLK,
   input  logic             RSTL,
   input  logic             WBUF_EN,
   input  logic [5:0]       WBUF_EN_CTRL,
   input  logic             WBUF_ALL_EN,
   input  logic             WBUF_SWITCH,
   input  logic             WBUF_PURGE,
   input  logic [DW-1:0]    QX,
   output logic [64*DW-1:0] WOUT,
   output logic             BANK_SEL,
   output logic [6:0]       LOAD_CNT,
   output logic             LOAD_FULL,
   output logic             ACTIVE_READY,
   output logic             OVWR
);

   logic [1:0][63:0] r_valid;
   logic             r_sel;
   logic             r_ovwr;
   logic             r_en_d;
   logic             r_all_d;
   logic [5:0]       r_idx_d;
   logic             r_tag_d;

   logic [1:0][63:0] w_we;
   logic [1:0][63:0] w_valid_nxt;
   logic             w_ovwr_hit;
   logic [6:0]       w_load_cnt;

   // One register per entry per bank; the delayed request decodes into a per-entry write strobe.
   for (genvar gi = 0; gi < 64; gi++) begin : g_ent
      for (genvar gb = 0; gb < 2; gb++) begin : g_bank
         logic [DW-1:0] r_word;

         assign w_we[gb][gi] = !WBUF_PURGE && (r_tag_d == 1'(gb)) &&
                               (r_all_d || (r_en_d && (r_idx_d == 6'(gi))));

         always_ff @(posedge CLK or negedge RSTL) begin
            if (!RSTL) begin
               r_word <= '0;
            end else if (w_we[gb][gi]) begin
               r_word <= QX;
            end
         end
      end

      assign WOUT[gi*DW +: DW] = r_sel ? g_bank[1].r_word : g_bank[0].r_word;
   end

   // The switch clear hits the outgoing active bank; a coincident write still sets its own bit.
   always_comb begin
      w_valid_nxt = r_valid;
      if (WBUF_SWITCH) begin
         w_valid_nxt[r_sel] = '0;
      end
      w_valid_nxt = w_valid_nxt | w_we;
   end

   assign w_ovwr_hit = |(r_valid[r_tag_d] & w_we[r_tag_d]);

   always_ff @(posedge CLK or negedge RSTL) begin
      if (!RSTL) begin
         r_valid <= '0;
         r_sel   <= 1'b0;
         r_ovwr  <= 1'b0;
         r_en_d  <= 1'b0;
         r_all_d <= 1'b0;
         r_idx_d <= '0;
         r_tag_d <= 1'b0;
      end else if (WBUF_PURGE) begin
         r_valid <= '0;
         r_sel   <= 1'b0;
         r_ovwr  <= 1'b0;
         r_en_d  <= 1'b0;
         r_all_d <= 1'b0;
         r_idx_d <= '0;
         r_tag_d <= 1'b0;
      end else begin
         r_valid <= w_valid_nxt;
         if (WBUF_SWITCH) begin
            r_sel <= ~r_sel;
         end
         if (w_ovwr_hit) begin
            r_ovwr <= 1'b1;
         end
         r_all_d <= WBUF_ALL_EN;
         r_en_d  <= WBUF_EN && !WBUF_ALL_EN;
         r_idx_d <= WBUF_EN_CTRL;
         r_tag_d <= ~r_sel;
      end
   end

   always_comb begin
      w_load_cnt = '0;
      for (int i = 0; i < 64; i++) begin
         w_load_cnt = w_load_cnt + 7'(r_valid[~r_sel][i]);
      end
   end

   assign BANK_SEL     = r_sel;
   assign LOAD_CNT     = w_load_cnt;
   assign LOAD_FULL    = &r_valid[~r_sel];
   assign ACTIVE_READY = &r_valid[r_sel];
   assign OVWR         = r_ovwr;

endmodule

// File: doc/wbuf_bank.md
WBUF_BANK -- requirements
Module: wbuf_bank

Interface
REQ-001 SHALL have parameter: DW, 16, bit width of one weight entry. Depth is fixed at 64 entries per bank, indexed by WBUF_EN_CTRL.
REQ-002 SHALL have port: CLK  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port: RSTL  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: WBUF_EN  input  1  single-entry write request (SRAM X read issued this cycle).
REQ-005 SHALL have port: WBUF_EN_CTRL  input  6  target entry index for WBUF_EN.
REQ-006 SHALL have port: WBUF_ALL_EN  input  1  broadcast write request (all 64 entries).
REQ-007 SHALL have port: WBUF_SWITCH  input  1  one-cycle pulse that swaps load and active banks.
REQ-008 SHALL have port: WBUF_PURGE  input  1  synchronous clear.
REQ-009 SHALL have port: QX  input  DW  SRAM X read data, valid one cycle after the request.
REQ-010 SHALL have port: WOUT  output  64*DW  active bank contents; entry i occupies bits [i*DW+DW-1 : i*DW].
REQ-011 SHALL have port: BANK_SEL  output  1  index of the active bank; the load bank is !BANK_SEL.
REQ-012 SHALL have port: LOAD_CNT  output  7  number of valid entries in the load bank, 0..64.
REQ-013 SHALL have port: LOAD_FULL  output  1  all 64 load-bank entries are valid.
REQ-014 SHALL have port: ACTIVE_READY  output  1  all 64 active-bank entries are valid.
REQ-015 SHALL have port: OVWR  output  1  sticky flag, set when a write hits an already-valid entry.

Function
REQ-016 SHALL hold two banks of 64 x DW registers plus one 64-bit valid bitmap per bank.
REQ-017 SHALL register a write request on its request edge: en_d, all_d, idx_d and bank tag tag_d = !BANK_SEL (the load bank at request time).
REQ-018 SHALL apply the write on the next edge (1-cycle latency, matching SRAM read latency):
- en_d: bank[tag_d][idx_d] <= QX and sets valid[tag_d][idx_d].
- all_d: every entry of bank[tag_d] <= QX and all 64 bits of valid[tag_d] are set.
REQ-019 SHALL give WBUF_ALL_EN precedence over WBUF_EN when both are asserted in the same cycle; only the broadcast occurs.
REQ-020 SHALL accept back-to-back requests every cycle with no bubbles; the pipeline is one stage deep and never stalls.
REQ-021 SHALL, on WBUF_SWITCH, toggle BANK_SEL at that edge and clear the valid bitmap of the bank becoming the load bank; data registers are retained.
REQ-022 SHALL, when a delayed write and WBUF_SWITCH share an edge, write to tag_d, which is the old load bank and now the active bank; that write's valid bit is set, and the bitmap clear applies only to the other bank.
REQ-023 SHALL, on a WBUF_SWITCH request cycle, capture any simultaneous write request with the pre-switch tag (!BANK_SEL before the toggle).
REQ-024 SHALL drive ACTIVE_READY = AND of valid[BANK_SEL], LOAD_FULL = AND of valid[!BANK_SEL], and LOAD_CNT = popcount of valid[!BANK_SEL], all combinational from registers.
REQ-025 SHALL allow WBUF_SWITCH when the load bank is not full, with no error; ACTIVE_READY is then 0.
REQ-026 SHALL set OVWR when an en_d write targets an entry whose valid bit is already 1, or when an all_d write targets a bank with any valid bit already 1; OVWR is cleared only by PURGE or reset.
REQ-027 SHALL, on WBUF_PURGE, at that edge:
- clear both bitmaps, BANK_SEL, OVWR and the pending request;
- ignore WBUF_EN, WBUF_ALL_EN and WBUF_SWITCH in the same cycle.
- Priority: PURGE > SWITCH > write.
REQ-028 SHALL keep WOUT driven from the active bank's registers at all times; no output gating by valid bits.

Reset
REQ-029 SHALL, with RSTL low, asynchronously clear:
- all data registers, bitmaps and the pending-request stage;
- BANK_SEL=0, OVWR=0.
- Outputs: WOUT=0, LOAD_CNT=0, LOAD_FULL=0, ACTIVE_READY=0.
REQ-030 SHALL discard any in-flight request on reset mid-operation; the first write after RSTL rises needs a fresh request.

Verification
REQ-031 SHALL cover: 64 consecutive WBUF_EN, idx 0..63, QX=idx+0x100 one cycle later -> LOAD_CNT counts 1..64, LOAD_FULL=1; WBUF_SWITCH -> BANK_SEL=1, ACTIVE_READY=1, WOUT entry 5 = 0x0105, LOAD_CNT=0.
REQ-032 SHALL cover: WBUF_ALL_EN with QX=0xABCD -> next edge LOAD_CNT=64, all load entries 0xABCD; WBUF_EN+WBUF_ALL_EN together, idx 3 -> broadcast only.
REQ-033 SHALL cover: write idx 63 in cycle N, WBUF_SWITCH in cycle N+1 -> entry 63 lands in the new active bank, ACTIVE_READY=1 if the other 63 were valid, new load bank LOAD_CNT=0.
REQ-034 SHALL cover: write idx 7 twice -> LOAD_CNT stays 1, OVWR=1, second value stored; WBUF_PURGE -> OVWR=0, LOAD_CNT=0, BANK_SEL=0.
REQ-035 SHALL cover: WBUF_PURGE and WBUF_SWITCH and WBUF_EN in one cycle -> BANK_SEL=0, no write the following edge.
REQ-036 SHALL cover: RSTL low one cycle after WBUF_EN -> no write after release, all outputs 0.
